// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: load/store op codes,
// access sizes (funct3 encoding) and responder FSM states.
package data_mem_responder_pkg;

  typedef enum logic [3:0] {
    MEM_NONE   = 4'd0,
    LOAD_DATA  = 4'd1,
    STORE_DATA = 4'd2
  } memory_operation_t;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_t;

  function automatic logic funct3_legal(
    input logic       is_store,
    input logic [2:0] f3
  );
    logic ok;
    ok = (f3 == MEM_B) || (f3 == MEM_H) || (f3 == MEM_W);
    if (!is_store) begin
      ok = ok || (f3 == MEM_BU) || (f3 == MEM_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane steering for the data RAM: store byte enables and data
// shift, load lane extract with sign/zero extension.
module dmem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic       is_b;
  logic       is_h;
  logic       sgn;
  logic [1:0] lo_eff;
  logic [31:0] rsh;

  always_comb begin
    is_b   = (funct3 == MEM_B) || (funct3 == MEM_BU);
    is_h   = (funct3 == MEM_H) || (funct3 == MEM_HU);
    sgn    = ~funct3[2];
    lo_eff = 2'b00;
    be     = 4'b1111;
    unique case (1'b1)
      is_b: begin
        lo_eff = addr_lo;
        be     = 4'b0001 << addr_lo;
      end
      is_h: begin
        // odd halfword addresses round down to the even lane pair
        lo_eff = {addr_lo[1], 1'b0};
        be     = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: begin
        lo_eff = 2'b00;
        be     = 4'b1111;
      end
    endcase
    wdata_sh = wdata << {lo_eff, 3'b000};
    rsh      = rword >> {lo_eff, 3'b000};
    rdata_ext = rsh;
    if (is_b) begin
      rdata_ext = {{24{sgn & rsh[7]}}, rsh[7:0]};
    end else if (is_h) begin
      rdata_ext = {{16{sgn & rsh[15]}}, rsh[15:0]};
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder with internal word RAM and fixed wait states.
// Define DMEM_MISALIGN_ERR_EN to fault misaligned H/W accesses.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          is_load;
  logic          is_store;
  logic          mis;
  logic          bad;
  logic          access;
  logic          we;
  logic [31:0]   rword;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   rdata_ext;

  always_comb begin
    off      = addr_q - BASE_ADDR;
    idx      = off[AW+1:2];
    is_load  = (op_q == LOAD_DATA);
    is_store = (op_q == STORE_DATA);
`ifdef DMEM_MISALIGN_ERR_EN
    mis = (((f3_q == MEM_H) || (f3_q == MEM_HU)) && addr_q[0]) ||
          ((f3_q == MEM_W) && (addr_q[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    // unknown op codes are accepted and answered with a fault
    bad = ({1'b0, off} >= LIMIT) ||
          !(is_load || is_store) ||
          !funct3_legal(is_store, f3_q) || mis;
    access = (state_q == DMEM_WAIT) && (cnt_q == 4'd0);
    we     = access && is_store && !bad && rst;
    rword  = mem_q[idx];
  end

  dmem_lane_align u_align (
    .funct3    (f3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    unique case (state_q)
      DMEM_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && (req_op != MEM_NONE)) begin
          op_d    = req_op;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WS;
          state_d = DMEM_WAIT;
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DMEM_RESP;
          err_d   = bad;
          rdata_d = (is_load && !bad) ? rdata_ext : 32'h0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DMEM_RESP: begin
        if (resp_ready) begin
          state_d = DMEM_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      f3_q    <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  assign resp_valid = (state_q == DMEM_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
